// File: rtl/itlb_tag_array.sv
// Fully-associative ITLB tag store: combinational lookup, fill/flush state visible the cycle after the edge.
// Flush has priority: fill_ready_o drops while flush_valid_i is high, and a held fill waits; flush_done_o pulses one cycle later.
module itlb_tag_array #(
  parameter int ENTRIES = 8,
  parameter int ASID_WD = 9,
  parameter int VPN1_WD = 10,
  parameter int VPN0_WD = 10,
  localparam int IDX_WD = $clog2(ENTRIES),
  localparam int VPN_WD = VPN1_WD + VPN0_WD
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ASID_WD-1:0] lkp_asid_i,
  input  logic [VPN_WD-1:0]  lkp_vpn_i,
  output logic              hit_o,
  output logic [IDX_WD-1:0] hit_idx_o,
  input  logic              fill_valid_i,
  output logic              fill_ready_o,
  input  logic [ASID_WD-1:0] fill_asid_i,
  input  logic [VPN_WD-1:0]  fill_vpn_i,
  input  logic              fill_g_i,
  input  logic              fill_super_i,
  output logic [IDX_WD-1:0] fill_idx_o,
  input  logic              flush_valid_i,
  input  logic              flush_asid_en_i,
  input  logic              flush_vpn_en_i,
  input  logic [ASID_WD-1:0] flush_asid_i,
  input  logic [VPN_WD-1:0]  flush_vpn_i,
  output logic              flush_done_o
);

  typedef struct packed {
    logic [ASID_WD-1:0] asid;
    logic [VPN1_WD-1:0] vpn1;
    logic [VPN0_WD-1:0] vpn0;
    logic               g;
    logic               sup;
  } tag_t;

  tag_t              tag_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [IDX_WD-1:0]  rr_q;
  logic               flush_done_q;

  logic [ENTRIES-1:0] lkp_match, fill_match, flush_match;
  logic               fill_hit, any_inv, fill_fire, rr_adv;
  logic [IDX_WD-1:0]  lkp_idx, fill_hit_idx, inv_idx, fill_tgt;

  always_comb begin
    lkp_match    = '0;
    fill_match   = '0;
    flush_match  = '0;
    lkp_idx      = '0;
    fill_hit_idx = '0;
    inv_idx      = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      logic vpn_m, asid_m;
      lkp_match[i] = valid_q[i] & (tag_q[i].g | (tag_q[i].asid == lkp_asid_i))
                   & (tag_q[i].vpn1 == lkp_vpn_i[VPN_WD-1:VPN0_WD])
                   & (tag_q[i].sup | (tag_q[i].vpn0 == lkp_vpn_i[VPN0_WD-1:0]));
      fill_match[i] = valid_q[i] & (tag_q[i].g | (tag_q[i].asid == fill_asid_i))
                    & (tag_q[i].vpn1 == fill_vpn_i[VPN_WD-1:VPN0_WD])
                    & (tag_q[i].sup | (tag_q[i].vpn0 == fill_vpn_i[VPN0_WD-1:0]));
      vpn_m  = (tag_q[i].vpn1 == flush_vpn_i[VPN_WD-1:VPN0_WD])
             & (tag_q[i].sup | (tag_q[i].vpn0 == flush_vpn_i[VPN0_WD-1:0]));
      asid_m = ~tag_q[i].g & (tag_q[i].asid == flush_asid_i);
      case ({flush_asid_en_i, flush_vpn_en_i})
        2'b00:   flush_match[i] = 1'b1;
        2'b10:   flush_match[i] = asid_m;
        2'b01:   flush_match[i] = vpn_m;
        default: flush_match[i] = asid_m & vpn_m;
      endcase
    end
    // Descending scan so the lowest index wins.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lkp_match[i])  lkp_idx      = IDX_WD'(i);
      if (fill_match[i]) fill_hit_idx = IDX_WD'(i);
      if (!valid_q[i])   inv_idx      = IDX_WD'(i);
    end
  end

  assign hit_o     = |lkp_match;
  assign hit_idx_o = lkp_idx;

  assign fill_hit     = |fill_match;
  assign any_inv      = ~&valid_q;
  assign fill_tgt     = fill_hit ? fill_hit_idx : (any_inv ? inv_idx : rr_q);
  assign fill_ready_o = ~flush_valid_i;
  assign fill_idx_o   = fill_tgt;
  assign fill_fire    = fill_valid_i & fill_ready_o;
  assign rr_adv       = fill_fire & ~fill_hit & ~any_inv;
  assign flush_done_o = flush_done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      rr_q         <= '0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) tag_q[i] <= '0;
    end else begin
      flush_done_q <= flush_valid_i;
      if (flush_valid_i) begin
        valid_q <= valid_q & ~flush_match;
      end else if (fill_fire) begin
        valid_q[fill_tgt] <= 1'b1;
        tag_q[fill_tgt]   <= '{asid: fill_asid_i,
                               vpn1: fill_vpn_i[VPN_WD-1:VPN0_WD],
                               vpn0: fill_vpn_i[VPN0_WD-1:0],
                               g:    fill_g_i,
                               sup:  fill_super_i};
      end
      if (rr_adv) rr_q <= rr_q + IDX_WD'(1);
    end
  end

endmodule

// File: tb/tb_itlb_tag_array.sv
// Directed bench for itlb_tag_array with a queue scoreboard of expected outputs.
module tb_itlb_tag_array;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [8:0]  lkp_asid_i, fill_asid_i, flush_asid_i;
  logic [19:0] lkp_vpn_i, fill_vpn_i, flush_vpn_i;
  logic        hit_o, fill_valid_i, fill_ready_o, fill_g_i, fill_super_i;
  logic [2:0]  hit_idx_o, fill_idx_o;
  logic        flush_valid_i, flush_asid_en_i, flush_vpn_en_i, flush_done_o;

  itlb_tag_array dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lkp_asid_i(lkp_asid_i), .lkp_vpn_i(lkp_vpn_i),
    .hit_o(hit_o), .hit_idx_o(hit_idx_o),
    .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o),
    .fill_asid_i(fill_asid_i), .fill_vpn_i(fill_vpn_i),
    .fill_g_i(fill_g_i), .fill_super_i(fill_super_i), .fill_idx_o(fill_idx_o),
    .flush_valid_i(flush_valid_i), .flush_asid_en_i(flush_asid_en_i),
    .flush_vpn_en_i(flush_vpn_en_i), .flush_asid_i(flush_asid_i),
    .flush_vpn_i(flush_vpn_i), .flush_done_o(flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [8:0] asid, input logic [19:0] vpn,
                        input logic exp_hit, input logic [2:0] exp_idx);
    lkp_asid_i = asid;
    lkp_vpn_i  = vpn;
    push({tag, "_hit"}, {31'd0, exp_hit});
    push({tag, "_idx"}, {29'd0, exp_idx});
    #1;
    cmp({31'd0, hit_o});
    cmp({29'd0, hit_idx_o});
  endtask

  task automatic fill(input string tag, input logic [8:0] asid, input logic [19:0] vpn,
                      input logic g, input logic sup, input logic [2:0] exp_idx);
    fill_asid_i  = asid;
    fill_vpn_i   = vpn;
    fill_g_i     = g;
    fill_super_i = sup;
    fill_valid_i = 1'b1;
    push({tag, "_rdy"}, 32'd1);
    push({tag, "_idx"}, {29'd0, exp_idx});
    #1;
    cmp({31'd0, fill_ready_o});
    cmp({29'd0, fill_idx_o});
    tick();
    fill_valid_i = 1'b0;
  endtask

  task automatic flush_drive(input logic ae, input logic ve, input logic [8:0] asid,
                             input logic [19:0] vpn);
    flush_asid_en_i = ae;
    flush_vpn_en_i  = ve;
    flush_asid_i    = asid;
    flush_vpn_i     = vpn;
    flush_valid_i   = 1'b1;
    push("flush_blocks_fill", 32'd0);
    #1;
    cmp({31'd0, fill_ready_o});
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    lkp_asid_i = '0; lkp_vpn_i = '0;
    fill_valid_i = 1'b0; fill_asid_i = '0; fill_vpn_i = '0; fill_g_i = 1'b0; fill_super_i = 1'b0;
    flush_valid_i = 1'b0; flush_asid_en_i = 1'b0; flush_vpn_en_i = 1'b0;
    flush_asid_i = '0; flush_vpn_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Reset state
    lookup("rst_lkp", 9'd2, 20'h00123, 1'b0, 3'd0);
    push("rst_done", 32'd0);
    cmp({31'd0, flush_done_o});

    // First fill; same-cycle lookup still sees the old state
    fill_asid_i = 9'd2; fill_vpn_i = 20'h004FF; fill_g_i = 1'b0; fill_super_i = 1'b0;
    fill_valid_i = 1'b1;
    lookup("same_cycle", 9'd2, 20'h004FF, 1'b0, 3'd0);
    fill_valid_i = 1'b0;
    fill("fill0", 9'd2, 20'h004FF, 1'b0, 1'b0, 3'd0);
    lookup("hit0", 9'd2, 20'h004FF, 1'b1, 3'd0);
    lookup("asid_miss", 9'd3, 20'h004FF, 1'b0, 3'd0);

    // Nine distinct keys into eight entries, then round-robin continues
    do_reset();
    for (int k = 0; k < 9; k++)
      fill("rr_fill", 9'd1, 20'h00100 + 20'(k), 1'b0, 1'b0, 3'(k % 8));
    lookup("evicted", 9'd1, 20'h00100, 1'b0, 3'd0);
    lookup("ninth", 9'd1, 20'h00108, 1'b1, 3'd0);
    lookup("second", 9'd1, 20'h00101, 1'b1, 3'd1);
    fill("tenth", 9'd1, 20'h00109, 1'b0, 1'b0, 3'd1);

    // Megapage, global, and refill without duplication
    do_reset();
    fill("mega", 9'd5, 20'h00400, 1'b1, 1'b1, 3'd0);
    lookup("mega_hit", 9'd7, 20'h007FF, 1'b1, 3'd0);
    fill("mega_refill", 9'd5, 20'h00400, 1'b1, 1'b1, 3'd0);
    fill("after_refill", 9'd5, 20'h00800, 1'b0, 1'b0, 3'd1);

    // Selective flushes
    do_reset();
    fill("fa0", 9'd2, 20'h00010, 1'b0, 1'b0, 3'd0);
    fill("fa1", 9'd2, 20'h00020, 1'b1, 1'b0, 3'd1);
    fill("fa2", 9'd3, 20'h00030, 1'b0, 1'b0, 3'd2);
    flush_drive(1'b1, 1'b0, 9'd2, 20'h0);
    push("done_pre", 32'd0);
    cmp({31'd0, flush_done_o});
    tick();
    flush_valid_i = 1'b0;
    push("done_asid", 32'd1);
    cmp({31'd0, flush_done_o});
    lookup("asid_fl_e0", 9'd2, 20'h00010, 1'b0, 3'd0);
    lookup("asid_fl_e1", 9'd2, 20'h00020, 1'b1, 3'd1);
    lookup("asid_fl_e2", 9'd3, 20'h00030, 1'b1, 3'd2);
    tick();
    push("done_drop", 32'd0);
    cmp({31'd0, flush_done_o});

    // VPN flush hits a global entry, then a back-to-back flush-all
    flush_drive(1'b0, 1'b1, 9'd0, 20'h00020);
    tick();
    flush_drive(1'b0, 1'b0, 9'd0, 20'h0);
    push("done_b2b_1", 32'd1);
    cmp({31'd0, flush_done_o});
    lookup("vpn_fl_e1", 9'd2, 20'h00020, 1'b0, 3'd0);
    lookup("vpn_fl_e2", 9'd3, 20'h00030, 1'b1, 3'd2);
    tick();
    flush_valid_i = 1'b0;
    push("done_b2b_2", 32'd1);
    cmp({31'd0, flush_done_o});
    lookup("all_fl_e2", 9'd3, 20'h00030, 1'b0, 3'd0);
    tick();
    push("done_b2b_end", 32'd0);
    cmp({31'd0, flush_done_o});

    // Fill held off by a simultaneous flush, accepted the next cycle
    fill_asid_i = 9'd4; fill_vpn_i = 20'h00044; fill_g_i = 1'b0; fill_super_i = 1'b0;
    fill_valid_i = 1'b1;
    flush_drive(1'b0, 1'b0, 9'd0, 20'h0);
    tick();
    flush_valid_i = 1'b0;
    lookup("held_not_written", 9'd4, 20'h00044, 1'b0, 3'd0);
    fill("held_accept", 9'd4, 20'h00044, 1'b0, 1'b0, 3'd0);
    lookup("held_hit", 9'd4, 20'h00044, 1'b1, 3'd0);

    // Advance rr_q, then reset mid-cycle with a fill pending
    for (int k = 1; k < 9; k++)
      fill("pre_rst", 9'd1, 20'h00200 + 20'(k), 1'b0, 1'b0, 3'(k % 8));
    fill_asid_i = 9'd1; fill_vpn_i = 20'h00300; fill_valid_i = 1'b1;
    #1;
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    fill_valid_i = 1'b0;
    tick();
    lookup("rst_pending", 9'd1, 20'h00300, 1'b0, 3'd0);
    lookup("rst_old", 9'd1, 20'h00201, 1'b0, 3'd0);
    push("rst_mid_done", 32'd0);
    cmp({31'd0, flush_done_o});
    for (int k = 0; k < 9; k++)
      fill("post_rst", 9'd1, 20'h00400 + 20'(k), 1'b0, 1'b0, 3'(k % 8));

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
